// File: rtl/b_imm_encoder_if.sv
// b_imm_encoder_if: branch-offset request in, encoded B-type instruction out, valid/ready on both sides.
interface b_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] offset;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        range_err;
  logic        align_err;
  modport master (
    output in_valid, offset, funct3, rs1, rs2, out_ready,
    input  in_ready, out_valid, instr, range_err, align_err
  );
  modport slave (
    input  in_valid, offset, funct3, rs1, rs2, out_ready,
    output in_ready, out_valid, instr, range_err, align_err
  );
endinterface

// File: rtl/b_imm_encoder.sv
// b_imm_encoder: one-entry registered B-type encoder with range/alignment flags.
// Define BIMM_ERR_CNT_EN to add the saturating error counter (clr_cnt/err_cnt ports).
module b_imm_encoder #(
  parameter logic [6:0] OPCODE = 7'b1100011
) (
  input  logic clk,
  input  logic rst_n,
  b_imm_encoder_if.slave bus
`ifdef BIMM_ERR_CNT_EN
  ,
  input  logic       clr_cnt,
  output logic [7:0] err_cnt
`endif
);
  logic        accept;
  logic        fits;
  logic [12:0] imm;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign imm = bus.offset[12:0];
  assign fits = bus.offset == {{19{imm[12]}}, imm};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.instr     <= '0;
      bus.range_err <= 1'b0;
      bus.align_err <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.instr     <= {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11], OPCODE};
      bus.range_err <= !fits;
      bus.align_err <= imm[0];
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
`ifdef BIMM_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (clr_cnt) err_cnt <= '0;
    else if (accept && (!fits || imm[0]) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_b_imm_encoder.sv
// tb_b_imm_encoder: directed vectors with hand-computed encodings, stall and async-reset checks.
module tb_b_imm_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  b_imm_encoder_if bus();
`ifdef BIMM_ERR_CNT_EN
  logic       clr_cnt = 1'b0;
  logic [7:0] err_cnt;
`endif
  b_imm_encoder dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
`ifdef BIMM_ERR_CNT_EN
    ,
    .clr_cnt(clr_cnt),
    .err_cnt(err_cnt)
`endif
  );
  typedef struct {
    logic [31:0] off;
    logic [2:0]  f3;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] instr;
    logic        rng;
    logic        aln;
  } vec_t;
  vec_t v[8] = '{
    '{32'h0000_0010, 3'd0, 5'd1,  5'd2,  32'h0020_8863, 1'b0, 1'b0},
    '{32'hFFFF_F000, 3'd0, 5'd0,  5'd0,  32'h8000_0063, 1'b0, 1'b0},
    '{32'h0000_1000, 3'd0, 5'd0,  5'd0,  32'h8000_0063, 1'b1, 1'b0},
    '{32'h0000_0005, 3'd1, 5'd3,  5'd4,  32'h0041_9263, 1'b0, 1'b1},
    '{32'hFFFF_FFFE, 3'd5, 5'd31, 5'd31, 32'hFFFF_DFE3, 1'b0, 1'b0},
    '{32'h0000_0800, 3'd0, 5'd0,  5'd0,  32'h0000_00E3, 1'b0, 1'b0},
    '{32'h0000_07FE, 3'd0, 5'd0,  5'd0,  32'h7E00_0F63, 1'b0, 1'b0},
    '{32'hFFFF_EFFE, 3'd0, 5'd0,  5'd0,  32'h7E00_0FE3, 1'b1, 1'b0}
  };
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic vld, input vec_t x);
    bus.in_valid = vld;
    bus.offset   = x.off;
    bus.funct3   = x.f3;
    bus.rs1      = x.r1;
    bus.rs2      = x.r2;
  endtask
  task automatic expect_out(input string tag, input vec_t x);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_instr"}, bus.instr, x.instr);
    check({tag, "_range"}, 32'(bus.range_err), 32'(x.rng));
    check({tag, "_align"}, 32'(bus.align_err), 32'(x.aln));
  endtask
  initial begin
    drive(1'b0, v[0]);
    bus.out_ready = 1'b1;
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_flags", {30'd0, bus.range_err, bus.align_err}, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, v[i]);
      step();
      expect_out($sformatf("vec%0d", i), v[i]);
    end
    drive(1'b0, v[0]);
    step();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, v[0]);
    step();
    expect_out("stall_a", v[0]);
    drive(1'b1, v[5]);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
      step();
      expect_out($sformatf("stall%0d", i), v[0]);
    end
    bus.out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    expect_out("stall_b", v[5]);
    drive(1'b0, v[0]);
    step();
    check("stall_nodup", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, v[4]);
    step();
    expect_out("pre_rst", v[4]);
    drive(1'b0, v[0]);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_instr", bus.instr, 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst%0d_valid", i), 32'(bus.out_valid), 32'd0);
    end
`ifdef BIMM_ERR_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("cnt_rst", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, v[3]);
    step();
    check("cnt_align", 32'(err_cnt), 32'd1);
    drive(1'b1, v[2]);
    for (int i = 0; i < 300; i++) step();
    check("cnt_sat", 32'(err_cnt), 32'd255);
    clr_cnt = 1'b1;
    step();
    check("cnt_clr", 32'(err_cnt), 32'd0);
    clr_cnt = 1'b0;
    drive(1'b1, v[0]);
    step();
    check("cnt_noerr", 32'(err_cnt), 32'd0);
    drive(1'b0, v[0]);
`endif
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/b_imm_encoder.md
B_IMM_ENCODER -- requirements
Module: b_imm_encoder

Interface
REQ-001 Parameter OPCODE, default 7'b1100011, opcode field placed in INSTR[6:0].
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 IN_VALID  input  1  upstream offer of a branch to encode.
REQ-005 IN_READY  output  1  block can accept this cycle.
REQ-006 OFFSET  input  32  signed byte branch offset.
REQ-007 FUNCT3  input  3  branch condition field.
REQ-008 RS1  input  5  first source register index.
REQ-009 RS2  input  5  second source register index.
REQ-010 OUT_VALID  output  1  INSTR and flags valid.
REQ-011 OUT_READY  input  1  downstream accepts this cycle.
REQ-012 INSTR  output  32  encoded B-type instruction word.
REQ-013 RANGE_ERR  output  1  OFFSET not representable as 13-bit signed.
REQ-014 ALIGN_ERR  output  1  OFFSET[0] set.
REQ-015 CLR_CNT  input  1  synchronous clear of ERR_CNT (present only with BIMM_ERR_CNT_EN).
REQ-016 ERR_CNT  output  8  error count (present only with BIMM_ERR_CNT_EN).

Function
REQ-017 The block SHALL accept a transaction on the edge where IN_VALID and IN_READY are both 1.
REQ-018 The block SHALL deliver a transaction on the edge where OUT_VALID and OUT_READY are both 1.
REQ-019 The block SHALL hold one registered output entry; IN_READY = !OUT_VALID || OUT_READY, combinational.
REQ-020 Latency SHALL be 1 cycle: OUT_VALID rises on the edge after acceptance.
REQ-021 Throughput SHALL be one transaction per cycle while OUT_READY stays 1.
REQ-022 With OUT_VALID=1 and OUT_READY=0, INSTR, RANGE_ERR and ALIGN_ERR SHALL hold stable and IN_READY SHALL be 0.
REQ-023 Simultaneous delivery and acceptance SHALL replace the entry with the new one, keeping OUT_VALID at 1.
REQ-024 Delivery without acceptance SHALL clear OUT_VALID on that edge.
REQ-025 INSTR SHALL be {imm[12], imm[10:5], RS2, RS1, FUNCT3, imm[4:1], imm[11], OPCODE}, where imm = OFFSET[12:0].
REQ-026 RANGE_ERR SHALL be 1 unless OFFSET[31:12] are all equal to OFFSET[12], i.e. unless the 32-bit sign extension of OFFSET[12:0] equals OFFSET.
REQ-027 ALIGN_ERR SHALL equal OFFSET[0]; imm[0] is dropped from INSTR.
REQ-028 Errored transactions SHALL still be delivered, with truncated immediate bits and their flags set.
REQ-029 RANGE_ERR and ALIGN_ERR SHALL be registered with INSTR and SHALL be meaningful only while OUT_VALID=1.

Reset
REQ-030 On RST_N low, the block SHALL immediately force OUT_VALID=0, INSTR=0, RANGE_ERR=0, ALIGN_ERR=0 and ERR_CNT=0, regardless of CLK.
REQ-031 An entry pending at reset SHALL be discarded and not delivered.
REQ-032 IN_READY SHALL read 1 while in reset.
REQ-033 The first acceptance SHALL occur on the first rising edge after RST_N deasserts.

Configuration
REQ-034 The error counter SHALL be compiled in by macro BIMM_ERR_CNT_EN.
REQ-035 With BIMM_ERR_CNT_EN defined, ERR_CNT SHALL increment by 1 on each accepted transaction with a range or alignment error.
REQ-036 ERR_CNT SHALL saturate at 255.
REQ-037 CLR_CNT=1 SHALL set ERR_CNT to 0 on the next edge and SHALL take priority over a simultaneous increment.
REQ-038 Without BIMM_ERR_CNT_EN, the CLR_CNT and ERR_CNT ports SHALL be absent and no counter logic SHALL exist.
REQ-039 All other behaviour SHALL be identical with or without BIMM_ERR_CNT_EN.

Verification
REQ-040 OFFSET=32'h00000010, FUNCT3=0, RS1=1, RS2=2, OUT_READY=1 -> next cycle OUT_VALID=1, INSTR=32'h00208863, both flags 0.
REQ-041 OFFSET=32'hFFFFF000 (-4096) -> INSTR[31]=1, INSTR[7]=0, RANGE_ERR=0; OFFSET=32'h00001000 -> RANGE_ERR=1.
REQ-042 OFFSET=32'h00000005 -> ALIGN_ERR=1 and the entry is still delivered; ERR_CNT 0->1 when the macro is defined.
REQ-043 Stall: OUT_READY=0 for 3 cycles with IN_VALID=1 -> IN_READY=0 and INSTR stable; OUT_READY=1 -> back-to-back delivery with no loss and no duplication.
REQ-044 RST_N pulsed low mid-stall -> OUT_VALID drops asynchronously, and the stalled entry never appears after release.
REQ-045 300 erroring transactions -> ERR_CNT=255; CLR_CNT coincident with an error -> ERR_CNT=0.
